memory_writeback: RTL and testbench
===================================

// Module: memory_writeback
// PURPOSE
//  Consumer end of the EX/MEM pipeline register: takes ALU result, store data, destination and
//  DMem/bus controls from execute, runs data-memory and accelerator-bus transactions, and drives
//  the register-file write port. Its writeback register feeds execute's forwarding data input.
//  It also generates the matching 2-bit forward select.
//  Stalls the pipeline while a memory or bus transaction is outstanding.
// PARAMETERS
//  DATA_W       16   datapath / address width
//  REG_AW       4    register index width
//  BUS_TIMEOUT  255  max BUS-state cycles without iBusAck before abort (1..2^TO_W-1)
//  TO_W         8    timeout counter width
// PORTS
//  clk         in   1       clock, all state on rising edge
//  rst_n       in   1       asynchronous active-low reset
//  iAluOut     in   DATA_W  ALU result; DMem/bus address for memory ops
//  iData2      in   DATA_W  store data
//  iDest       in   REG_AW  destination register
//  iAlutoReg   in   1       write ALU result to register
//  iMemtoReg   in   1       write DMem read data to register (with iMemRead)
//  iBustoReg   in   1       bus read; write bus data to register
//  iMemRead    in   1       DMem read
//  iMemWrite   in   1       DMem write
//  iBusWrite   in   1       bus write
//  iExSr1      in   REG_AW  source 1 of instruction currently in execute
//  iExSr2      in   REG_AW  source 2 of instruction currently in execute
//  oDmemAddr   out  DATA_W  DMem address (registered)
//  oDmemWData  out  DATA_W  DMem write data (registered)
//  oDmemRe     out  1       DMem read strobe, held until iDmemValid
//  oDmemWe     out  1       DMem write strobe, held until iDmemValid
//  iDmemValid  in   1       DMem done (read data valid / write accepted)
//  iDmemRData  in   DATA_W  DMem read data, sampled when iDmemValid=1
//  oBusReq     out  1       bus request, held until iBusAck or timeout
//  oBusWr      out  1       1=write, 0=read; stable while oBusReq=1
//  oBusAddr    out  DATA_W  bus address
//  oBusWData   out  DATA_W  bus write data
//  iBusAck     in   1       bus completion
//  iBusRData   in   DATA_W  bus read data, sampled with iBusAck
//  oBusErr     out  1       one-cycle pulse: bus transaction timed out
//  oStall      out  1       freeze upstream pipeline (combinational)
//  oWbEn       out  1       register-file write enable (registered)
//  oWbDest     out  REG_AW  register-file write index (registered)
//  oWbData     out  DATA_W  register-file write data (registered) = execute's writeback-data input
//  oForward    out  2       [0]: forward oWbData to ALU input 1; [1]: to ALU input 2 / store data
// BEHAVIOUR
//  Reset: state IDLE, timeout counter 0, every output 0; an in-flight request is dropped.
//  FSM: IDLE, MEM, BUS, DONE.
//  Op select in IDLE, priority: iMemWrite > iMemRead > iBusWrite > iBustoReg. Lower-priority flags ignored.
//  oStall = (IDLE & any op flag) | MEM | BUS; 0 in DONE. Inputs must hold stable while oStall=1.
//  IDLE, no op: next edge loads oWbEn = iAlutoReg, oWbDest = iDest, oWbData = iAluOut (1-cycle latency).
//  IDLE, op: next edge goes to MEM/BUS and registers strobe, address = iAluOut, data = iData2;
//   oWbEn <= 0; bus timeout counter cleared.
//  MEM: strobe held. iDmemValid=1 -> capture iDmemRData (read), drop strobe, go DONE.
//  BUS: oBusReq held; counter +1 per cycle.
//   iBusAck=1 -> capture iBusRData, drop oBusReq, go DONE.
//   No ack and counter = BUS_TIMEOUT-1 -> drop oBusReq, captured data = 0, oBusErr=1 in DONE, go DONE.
//   Ack on the timeout cycle counts as success.
//  DONE (1 cycle, oStall=0): edge loads oWbDest = iDest and oWbData = captured data;
//   oWbEn = iMemtoReg for DMem read, iBustoReg for bus read, 0 for writes. Returns to IDLE.
//   Net stall: 2 + wait cycles, where wait >= 0 is cycles after the strobe before valid/ack.
//  oForward[0] = oWbEn & (oWbDest == iExSr1); oForward[1] = oWbEn & (oWbDest == iExSr2). Combinational.
//   Register 0 is not special.
//  Widths: all data unmodified DATA_W. No sign extension.
// TESTING
//  ALU op iAlutoReg=1, iDest=3, iAluOut=16'h1234; iExSr2=3
//   -> next cycle oWbEn=1, oWbDest=3, oWbData=16'h1234, oForward=2'b10, oStall never high.
//  DMem read iMemRead=iMemtoReg=1, addr 16'h0040; iDmemValid 2 cycles after oDmemRe with 16'hBEEF
//   -> oStall high 4 cycles, then oWbData=16'hBEEF, oWbEn=1.
//  DMem write addr 16'h0010, data 16'h00AA; immediate valid
//   -> oDmemWe=1 for 1 cycle with that addr/data, oWbEn=0, 2-cycle stall.
//  Bus read, BUS_TIMEOUT=4, no ack
//   -> oBusReq high 4 cycles, oBusErr 1-cycle pulse, oWbData=0, oWbEn=1, pipeline resumes.
//  iMemWrite=iBusWrite=1 simultaneously -> only DMem write issued, oBusReq stays 0.
//  rst_n low while in BUS -> oBusReq, oStall, oWbEn all 0 immediately. After release, IDLE accepts new op.

Source files
------------

// File: rtl/memory_writeback.sv
// -----------------------------------------------------------------------------
// memory_writeback
//
// Consumer end of the EX/MEM pipeline register. A single instruction is taken
// from execute each time the block is idle and is either
//   * retired directly (ALU result written to the register file next edge), or
//   * turned into a data-memory or accelerator-bus transaction, during which
//     the upstream pipeline is frozen through oStall.
// The writeback register (oWbEn/oWbDest/oWbData) is also the forwarding source
// for execute; oForward tells execute which of its operands should take it.
//
// Ports
//   clk, rst_n                 clock (rising edge), asynchronous active-low reset
//   iAluOut, iData2, iDest     ALU result / memory address, store data, dest reg
//   iAlutoReg, iMemtoReg,      writeback selects
//   iBustoReg
//   iMemRead, iMemWrite,       operation flags (priority MemWrite > MemRead >
//   iBusWrite, iBustoReg       BusWrite > BustoReg(bus read))
//   iExSr1, iExSr2             source registers of the instruction in execute
//   oDmemAddr/WData/Re/We      data-memory request (registered, held to iDmemValid)
//   iDmemValid, iDmemRData     data-memory completion and read data
//   oBusReq/Wr/Addr/WData      bus request (registered, held to ack or timeout)
//   iBusAck, iBusRData         bus completion and read data
//   oBusErr                    one-cycle pulse when a bus transaction timed out
//   oStall                     freeze upstream pipeline (combinational)
//   oWbEn/oWbDest/oWbData      register-file write port (registered)
//   oForward                   [0] forward to ALU input 1, [1] to input 2 / store
// -----------------------------------------------------------------------------
module memory_writeback #(
  parameter int DATA_W      = 16,
  parameter int REG_AW      = 4,
  parameter int BUS_TIMEOUT = 255,
  parameter int TO_W        = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] iAluOut,
  input  logic [DATA_W-1:0] iData2,
  input  logic [REG_AW-1:0] iDest,
  input  logic              iAlutoReg,
  input  logic              iMemtoReg,
  input  logic              iBustoReg,
  input  logic              iMemRead,
  input  logic              iMemWrite,
  input  logic              iBusWrite,
  input  logic [REG_AW-1:0] iExSr1,
  input  logic [REG_AW-1:0] iExSr2,
  output logic [DATA_W-1:0] oDmemAddr,
  output logic [DATA_W-1:0] oDmemWData,
  output logic              oDmemRe,
  output logic              oDmemWe,
  input  logic              iDmemValid,
  input  logic [DATA_W-1:0] iDmemRData,
  output logic              oBusReq,
  output logic              oBusWr,
  output logic [DATA_W-1:0] oBusAddr,
  output logic [DATA_W-1:0] oBusWData,
  input  logic              iBusAck,
  input  logic [DATA_W-1:0] iBusRData,
  output logic              oBusErr,
  output logic              oStall,
  output logic              oWbEn,
  output logic [REG_AW-1:0] oWbDest,
  output logic [DATA_W-1:0] oWbData,
  output logic [1:0]        oForward
);

  // Last counter value the BUS state may reach; with no ack on that cycle the
  // transaction is abandoned, giving exactly BUS_TIMEOUT cycles of oBusReq.
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(BUS_TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_MEM, S_BUS, S_DONE} state_t;
  // Kind of transaction in flight; remembered so DONE knows how to retire it.
  typedef enum logic [1:0] {K_MWR, K_MRD, K_BWR, K_BRD} kind_t;

  state_t            state;
  state_t            state_nx;
  kind_t             kind;
  kind_t             kind_sel;
  logic              any_op;
  logic              mem_sel;
  logic              to_hit;
  logic [TO_W-1:0]   to_cnt;
  logic [DATA_W-1:0] cap_data;

  assign any_op  = iMemWrite | iMemRead | iBusWrite | iBustoReg;
  assign mem_sel = iMemWrite | iMemRead;
  assign to_hit  = (to_cnt == TO_LAST);

  // Operation priority: lower-priority flags are simply ignored.
  always_comb begin
    kind_sel = K_BRD;
    if (iMemWrite)      kind_sel = K_MWR;
    else if (iMemRead)  kind_sel = K_MRD;
    else if (iBusWrite) kind_sel = K_BWR;
  end

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // ---------------------------------------------------------------------------
  // FSM next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (any_op) state_nx = mem_sel ? S_MEM : S_BUS;
      S_MEM:  if (iDmemValid) state_nx = S_DONE;
      S_BUS:  if (iBusAck || to_hit) state_nx = S_DONE;
      S_DONE: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM combinational outputs
  // ---------------------------------------------------------------------------
  // The stall is masked during reset so the pipeline is released at once even
  // though execute may still be presenting the aborted instruction.
  always_comb begin
    oStall = 1'b0;
    case (state)
      S_IDLE:  oStall = any_op;
      S_MEM:   oStall = 1'b1;
      S_BUS:   oStall = 1'b1;
      default: oStall = 1'b0;
    endcase
    if (!rst_n) oStall = 1'b0;
  end

  assign oForward = {oWbEn & (oWbDest == iExSr2), oWbEn & (oWbDest == iExSr1)};

  // ---------------------------------------------------------------------------
  // Transaction and writeback registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kind       <= K_MWR;
      to_cnt     <= '0;
      cap_data   <= '0;
      oDmemAddr  <= '0;
      oDmemWData <= '0;
      oDmemRe    <= 1'b0;
      oDmemWe    <= 1'b0;
      oBusReq    <= 1'b0;
      oBusWr     <= 1'b0;
      oBusAddr   <= '0;
      oBusWData  <= '0;
      oBusErr    <= 1'b0;
      oWbEn      <= 1'b0;
      oWbDest    <= '0;
      oWbData    <= '0;
    end else begin
      oBusErr <= 1'b0;
      case (state)
        S_IDLE: begin
          if (any_op) begin
            kind   <= kind_sel;
            oWbEn  <= 1'b0;
            to_cnt <= '0;
            if (mem_sel) begin
              oDmemAddr  <= iAluOut;
              oDmemWData <= iData2;
              oDmemWe    <= iMemWrite;
              oDmemRe    <= ~iMemWrite;
            end else begin
              oBusReq   <= 1'b1;
              oBusWr    <= iBusWrite;
              oBusAddr  <= iAluOut;
              oBusWData <= iData2;
            end
          end else begin
            oWbEn   <= iAlutoReg;
            oWbDest <= iDest;
            oWbData <= iAluOut;
          end
        end
        S_MEM: begin
          if (iDmemValid) begin
            oDmemRe <= 1'b0;
            oDmemWe <= 1'b0;
            if (kind == K_MRD) cap_data <= iDmemRData;
          end
        end
        S_BUS: begin
          to_cnt <= to_cnt + TO_W'(1);
          // An ack arriving on the final allowed cycle still wins.
          if (iBusAck) begin
            oBusReq  <= 1'b0;
            cap_data <= iBusRData;
          end else if (to_hit) begin
            oBusReq  <= 1'b0;
            cap_data <= '0;
            oBusErr  <= 1'b1;
          end
        end
        S_DONE: begin
          oWbDest <= iDest;
          oWbData <= cap_data;
          case (kind)
            K_MRD:   oWbEn <= iMemtoReg;
            K_BRD:   oWbEn <= iBustoReg;
            default: oWbEn <= 1'b0;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_writeback.sv
module tb_memory_writeback;

  localparam int DW = 16;
  localparam int AW = 4;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] iAluOut, iData2;
  logic [AW-1:0] iDest, iExSr1, iExSr2;
  logic          iAlutoReg, iMemtoReg, iBustoReg, iMemRead, iMemWrite, iBusWrite;
  logic [DW-1:0] oDmemAddr, oDmemWData;
  logic          oDmemRe, oDmemWe, iDmemValid;
  logic [DW-1:0] iDmemRData;
  logic          oBusReq, oBusWr;
  logic [DW-1:0] oBusAddr, oBusWData;
  logic          iBusAck;
  logic [DW-1:0] iBusRData;
  logic          oBusErr, oStall, oWbEn;
  logic [AW-1:0] oWbDest;
  logic [DW-1:0] oWbData;
  logic [1:0]    oForward;

  int n_cmp = 0;
  int n_fail = 0;

  memory_writeback #(.DATA_W(DW), .REG_AW(AW), .BUS_TIMEOUT(TO), .TO_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .iAluOut(iAluOut), .iData2(iData2), .iDest(iDest),
    .iAlutoReg(iAlutoReg), .iMemtoReg(iMemtoReg), .iBustoReg(iBustoReg),
    .iMemRead(iMemRead), .iMemWrite(iMemWrite), .iBusWrite(iBusWrite),
    .iExSr1(iExSr1), .iExSr2(iExSr2),
    .oDmemAddr(oDmemAddr), .oDmemWData(oDmemWData), .oDmemRe(oDmemRe), .oDmemWe(oDmemWe),
    .iDmemValid(iDmemValid), .iDmemRData(iDmemRData),
    .oBusReq(oBusReq), .oBusWr(oBusWr), .oBusAddr(oBusAddr), .oBusWData(oBusWData),
    .iBusAck(iBusAck), .iBusRData(iBusRData), .oBusErr(oBusErr),
    .oStall(oStall), .oWbEn(oWbEn), .oWbDest(oWbDest), .oWbData(oWbData),
    .oForward(oForward)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    iAlutoReg = 0; iMemtoReg = 0; iBustoReg = 0;
    iMemRead = 0; iMemWrite = 0; iBusWrite = 0;
  endtask

  // Runs one instruction through the block. wt = cycles after the strobe before
  // the responder answers (a value >= TO means a bus never answers).
  // Expectations come from the instruction-level rules only.
  task automatic run_op(input string tag,
                        input logic alu, input logic mtr, input logic btr,
                        input logic mrd, input logic mwr, input logic bwr,
                        input logic [DW-1:0] aout, input logic [DW-1:0] d2,
                        input logic [AW-1:0] dest, input int wt,
                        input logic [DW-1:0] rdata,
                        input logic [AW-1:0] sr1, input logic [AW-1:0] sr2);
    int kind;          // 0 none, 1 dmem write, 2 dmem read, 3 bus write, 4 bus read
    bit tmo;
    int w_eff, exp_stall;
    logic exp_en;
    logic [DW-1:0] exp_data;
    int n_stall, n_re, n_we, n_req, n_err, cnt;
    bit done, seen;

    kind = mwr ? 1 : mrd ? 2 : bwr ? 3 : btr ? 4 : 0;
    tmo = (kind >= 3) && (wt >= TO);
    w_eff = tmo ? TO - 1 : wt;
    exp_stall = (kind == 0) ? 0 : 2 + w_eff;
    exp_en = 1'b0;
    exp_data = '0;
    case (kind)
      0: begin exp_en = alu; exp_data = aout; end
      2: begin exp_en = mtr; exp_data = rdata; end
      4: begin exp_en = 1'b1; exp_data = tmo ? '0 : rdata; end
      default: exp_en = 1'b0;
    endcase

    iAlutoReg = alu; iMemtoReg = mtr; iBustoReg = btr;
    iMemRead = mrd; iMemWrite = mwr; iBusWrite = bwr;
    iAluOut = aout; iData2 = d2; iDest = dest;

    n_stall = 0; n_re = 0; n_we = 0; n_req = 0; n_err = 0; cnt = 0;
    done = 0; seen = 0;
    for (int c = 0; c < 64; c++) begin
      iDmemValid = 0;
      iBusAck = 0;
      if (oDmemRe || oDmemWe) begin
        if (!seen) begin
          seen = 1;
          chk($sformatf("%s_dmem_addr", tag), 32'(oDmemAddr), 32'(aout));
          chk($sformatf("%s_dmem_wdata", tag), 32'(oDmemWData), 32'(d2));
        end
        if (oDmemRe) n_re++;
        if (oDmemWe) n_we++;
        iDmemValid = (cnt == wt);
        cnt++;
      end
      if (oBusReq) begin
        if (!seen) begin
          seen = 1;
          chk($sformatf("%s_bus_addr", tag), 32'(oBusAddr), 32'(aout));
          chk($sformatf("%s_bus_wdata", tag), 32'(oBusWData), 32'(d2));
          chk($sformatf("%s_bus_wr", tag), 32'(oBusWr), 32'(kind == 3));
        end
        n_req++;
        iBusAck = (cnt == wt);
        cnt++;
      end
      iDmemRData = iDmemValid ? rdata : ~rdata;
      iBusRData  = iBusAck ? rdata : ~rdata;
      #1;
      if (oStall) n_stall++;
      else done = 1;
      if (oBusErr) n_err++;
      step();
      iDmemValid = 0;
      iBusAck = 0;
      if (done) break;
    end

    chk($sformatf("%s_completed", tag), 32'(done), 32'd1);
    chk($sformatf("%s_stall_cycles", tag), 32'(n_stall), 32'(exp_stall));
    chk($sformatf("%s_dmem_re_cycles", tag), 32'(n_re), 32'((kind == 2) ? w_eff + 1 : 0));
    chk($sformatf("%s_dmem_we_cycles", tag), 32'(n_we), 32'((kind == 1) ? w_eff + 1 : 0));
    chk($sformatf("%s_bus_req_cycles", tag), 32'(n_req), 32'((kind >= 3) ? w_eff + 1 : 0));
    chk($sformatf("%s_bus_err_pulses", tag), 32'(n_err), 32'(tmo));
    chk($sformatf("%s_wb_en", tag), 32'(oWbEn), 32'(exp_en));
    chk($sformatf("%s_wb_dest", tag), 32'(oWbDest), 32'(dest));
    if (kind == 0 || kind == 2 || kind == 4)
      chk($sformatf("%s_wb_data", tag), 32'(oWbData), 32'(exp_data));

    drive_idle();
    iExSr1 = sr1;
    iExSr2 = sr2;
    #1;
    chk($sformatf("%s_forward", tag), 32'(oForward),
        32'({exp_en && (dest == sr2), exp_en && (dest == sr1)}));
    chk($sformatf("%s_stall_after", tag), 32'(oStall), 32'd0);
  endtask

  initial begin
    logic [AW-1:0] rd;
    rst_n = 0;
    drive_idle();
    iAluOut = '0; iData2 = '0; iDest = '0; iExSr1 = '0; iExSr2 = '0;
    iDmemValid = 0; iDmemRData = '0; iBusAck = 0; iBusRData = '0;
    step(); step(); step();

    // Reset state
    chk("rst_wb_en", 32'(oWbEn), 32'd0);
    chk("rst_wb_dest", 32'(oWbDest), 32'd0);
    chk("rst_wb_data", 32'(oWbData), 32'd0);
    chk("rst_dmem_re", 32'(oDmemRe), 32'd0);
    chk("rst_dmem_we", 32'(oDmemWe), 32'd0);
    chk("rst_dmem_addr", 32'(oDmemAddr), 32'd0);
    chk("rst_bus_req", 32'(oBusReq), 32'd0);
    chk("rst_bus_err", 32'(oBusErr), 32'd0);
    chk("rst_stall", 32'(oStall), 32'd0);
    chk("rst_forward", 32'(oForward), 32'd0);
    rst_n = 1;
    step();

    // Directed cases
    run_op("alu", 1, 0, 0, 0, 0, 0, 16'h1234, 16'h0000, 4'd3, 0, 16'h0000, 4'd5, 4'd3);
    run_op("dmem_rd", 0, 1, 0, 1, 0, 0, 16'h0040, 16'h0000, 4'd7, 2, 16'hBEEF, 4'd7, 4'd1);
    run_op("dmem_wr", 0, 0, 0, 0, 1, 0, 16'h0010, 16'h00AA, 4'd2, 0, 16'h5555, 4'd2, 4'd2);
    run_op("bus_tmo", 0, 0, 1, 0, 0, 0, 16'h0300, 16'h0000, 4'd9, 99, 16'hCAFE, 4'd9, 4'd9);
    run_op("prio", 0, 0, 0, 0, 1, 1, 16'h0020, 16'h0077, 4'd4, 1, 16'h1111, 4'd0, 4'd0);
    run_op("bus_ack_last", 0, 0, 1, 0, 0, 0, 16'h0400, 16'h0000, 4'd0, TO - 1, 16'hA5A5, 4'd0, 4'd1);
    run_op("bus_wr", 0, 0, 0, 0, 0, 1, 16'h0500, 16'h4242, 4'd6, 0, 16'h0000, 4'd6, 4'd6);

    // Reset while a bus transaction is outstanding
    iBustoReg = 1; iAluOut = 16'h0600; iDest = 4'd8;
    step(); step(); step();
    chk("busrst_req_before", 32'(oBusReq), 32'd1);
    rst_n = 0;
    #1;
    chk("busrst_req", 32'(oBusReq), 32'd0);
    chk("busrst_stall", 32'(oStall), 32'd0);
    chk("busrst_wb_en", 32'(oWbEn), 32'd0);
    drive_idle();
    step();
    rst_n = 1;
    step();
    run_op("post_rst", 0, 1, 0, 1, 0, 0, 16'h0044, 16'h0000, 4'd1, 1, 16'h0F0F, 4'd1, 4'd1);

    // Randomized instructions
    for (int i = 0; i < 30; i++) begin
      rd = 4'($urandom_range(0, 15));
      run_op($sformatf("rnd%0d", i),
             1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0),
             1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 4) == 0),
             1'($urandom_range(0, 4) == 0),
             16'($urandom), 16'($urandom), rd, int'($urandom_range(0, 6)), 16'($urandom),
             ($urandom_range(0, 1) == 1) ? rd : 4'($urandom_range(0, 15)),
             ($urandom_range(0, 1) == 1) ? rd : 4'($urandom_range(0, 15)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
